// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage.
// Retires one ROB head entry per cycle. It produces the register-file write
// and the retire counter, and on a mispredicted jump it redirects the PC and
// holds a pipeline flush for FLUSH_CYCLES cycles.
module commit_unit #(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        transmit_from_rob,
   input  logic [3:0]  rob_pos_from_rob,
   input  logic [4:0]  regfile_pos_from_rob,
   input  logic [31:0] data_from_rob,
   input  logic [31:0] jump_addr_from_rob,
   input  logic [1:0]  type_from_rob,
   input  logic        jump_from_rob,
   output logic        rdy_to_rob,
   output logic        flush_to_all,
   output logic        transmit_to_regfile,
   output logic [4:0]  regfile_pos_to_regfile,
   output logic [31:0] data_to_regfile,
   output logic [3:0]  rob_pos_to_regfile,
   output logic        transmit_to_pc,
   output logic [31:0] pc_to_pc,
   output logic [31:0] commit_count_out
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   localparam logic [1:0] TYPE_JUMP  = 2'b01;
   // Loaded on entry to FLUSH; state leaves FLUSH once it has counted down to zero.
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   state_t      state_q;
   logic [2:0]  flush_cnt_q;
   logic        flush_q;
   logic        wr_en_q;
   logic [4:0]  wr_pos_q;
   logic [31:0] wr_data_q;
   logic [3:0]  rob_pos_q;
   logic        redirect_q;
   logic [31:0] pc_q;
   logic [31:0] count_q;

   logic        accept_s;
   logic        mispredict_s;

   // Acceptance is purely combinational so the ROB head can advance in the same cycle.
   always_comb begin
      accept_s     = 1'b0;
      mispredict_s = 1'b0;
      if (rdy_in && !rst_in && (state_q == IDLE) && transmit_from_rob) begin
         accept_s     = 1'b1;
         mispredict_s = (type_from_rob == TYPE_JUMP) && jump_from_rob;
      end else begin
         accept_s     = 1'b0;
         mispredict_s = 1'b0;
      end
   end

   // Retire FSM: IDLE retires entries, FLUSH discards wrong-path entries for the flush window.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         flush_cnt_q <= 3'd0;
         flush_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_pos_q    <= 5'd0;
         wr_data_q   <= 32'd0;
         rob_pos_q   <= 4'd0;
         redirect_q  <= 1'b0;
         pc_q        <= 32'd0;
         count_q     <= 32'd0;
      end else if (rdy_in) begin
         case (state_q)
            IDLE: begin
               // Strobes are single-cycle pulses unless re-armed by a new accept.
               wr_en_q    <= accept_s && (regfile_pos_from_rob != 5'd0);
               redirect_q <= 1'b0;
               if (accept_s) begin
                  wr_pos_q  <= regfile_pos_from_rob;
                  wr_data_q <= data_from_rob;
                  rob_pos_q <= rob_pos_from_rob;
                  count_q   <= count_q + 32'd1;
               end
               if (mispredict_s) begin
                  redirect_q  <= 1'b1;
                  pc_q        <= jump_addr_from_rob;
                  flush_q     <= 1'b1;
                  flush_cnt_q <= FLUSH_INIT;
                  state_q     <= FLUSH;
               end
            end
            FLUSH: begin
               wr_en_q    <= 1'b0;
               redirect_q <= 1'b0;
               if (flush_cnt_q == 3'd0) begin
                  flush_q <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  flush_q     <= 1'b1;
                  flush_cnt_q <= flush_cnt_q - 3'd1;
               end
            end
            default: begin
               state_q     <= IDLE;
               flush_cnt_q <= 3'd0;
               flush_q     <= 1'b0;
               wr_en_q     <= 1'b0;
               redirect_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdy_to_rob             = accept_s;
   assign flush_to_all           = flush_q;
   assign transmit_to_regfile    = wr_en_q;
   assign regfile_pos_to_regfile = wr_pos_q;
   assign data_to_regfile        = wr_data_q;
   assign rob_pos_to_regfile     = rob_pos_q;
   assign transmit_to_pc         = redirect_q;
   assign pc_to_pc               = pc_q;
   assign commit_count_out       = count_q;

endmodule

// File: tb/tb_commit_unit.sv
// tb_commit_unit: scoreboard bench for commit_unit.
// The driver applies one input vector per cycle and advances a transaction-level
// model; expected writes and redirects are queued. A separate monitor pops the
// queues and compares against the DUT after each rising edge.
module tb_commit_unit;

   localparam int unsigned FC = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b0;
   logic        tx = 1'b0;
   logic [3:0]  pos = 4'd0;
   logic [4:0]  rd = 5'd0;
   logic [31:0] data = 32'd0;
   logic [31:0] addr = 32'd0;
   logic [1:0]  typ = 2'd0;
   logic        jmp = 1'b0;

   logic        rdy_to_rob, flush_to_all, transmit_to_regfile, transmit_to_pc;
   logic [4:0]  regfile_pos_to_regfile;
   logic [31:0] data_to_regfile, pc_to_pc, commit_count_out;
   logic [3:0]  rob_pos_to_regfile;

   commit_unit #(.FLUSH_CYCLES(FC)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .transmit_from_rob(tx),
      .rob_pos_from_rob(pos), .regfile_pos_from_rob(rd), .data_from_rob(data),
      .jump_addr_from_rob(addr), .type_from_rob(typ), .jump_from_rob(jmp),
      .rdy_to_rob(rdy_to_rob), .flush_to_all(flush_to_all),
      .transmit_to_regfile(transmit_to_regfile),
      .regfile_pos_to_regfile(regfile_pos_to_regfile),
      .data_to_regfile(data_to_regfile), .rob_pos_to_regfile(rob_pos_to_regfile),
      .transmit_to_pc(transmit_to_pc), .pc_to_pc(pc_to_pc),
      .commit_count_out(commit_count_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic [3:0]  pos;
   } wr_t;

   wr_t         wr_q[$];
   logic [31:0] pc_q[$];

   // Reference model state, expressed as "how many more enabled cycles stay blocked".
   int          blocked = 0;
   logic [31:0] m_count = 32'd0;
   logic [3:0]  m_pos = 4'd0;
   logic [31:0] m_pc = 32'd0;
   int          n_vec = 0;
   int          n_bad = 0;
   int          n_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive, check the combinational accept, advance the model.
   task automatic cyc(input logic r, input logic e, input logic t, input logic [3:0] p,
                      input logic [4:0] d, input logic [31:0] v, input logic [31:0] a,
                      input logic [1:0] ty, input logic j);
      logic acc;
      @(negedge clk);
      rst = r; rdy = e; tx = t; pos = p; rd = d; data = v; addr = a; typ = ty; jmp = j;
      #1;
      acc = e && !r && (blocked == 0) && t;
      check("rdy_to_rob", {31'd0, rdy_to_rob}, {31'd0, acc});
      if (r) begin
         blocked = 0; m_count = 32'd0; m_pos = 4'd0; m_pc = 32'd0;
      end else if (e) begin
         if (acc) begin
            n_acc++;
            m_count = m_count + 32'd1;
            m_pos = p;
            if (d != 5'd0) wr_q.push_back('{rd: d, data: v, pos: p});
            if (ty == 2'b01 && j) begin
               pc_q.push_back(a);
               m_pc = a;
               blocked = FC;
            end
         end else if (blocked > 0) begin
            blocked = blocked - 1;
         end
      end
   endtask

   task automatic idle_cyc(input logic t);
      cyc(1'b0, 1'b1, t, 4'd0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0);
   endtask

   // Monitor: after each edge compare the DUT against the scoreboard and model.
   initial begin
      logic en, rs;
      forever begin
         @(posedge clk);
         en = rdy && !rst;
         rs = rst;
         #1;
         check("flush_to_all", {31'd0, flush_to_all}, {31'd0, blocked > 0});
         check("commit_count", commit_count_out, m_count);
         check("rob_pos", {28'd0, rob_pos_to_regfile}, {28'd0, m_pos});
         check("pc_to_pc", pc_to_pc, m_pc);
         if (rs) begin
            check("rst_wr", {31'd0, transmit_to_regfile}, 32'd0);
            check("rst_pc", {31'd0, transmit_to_pc}, 32'd0);
            check("rst_data", data_to_regfile, 32'd0);
            check("rst_rd", {27'd0, regfile_pos_to_regfile}, 32'd0);
            wr_q.delete();
            pc_q.delete();
         end else if (en) begin
            if (wr_q.size() > 0) begin
               wr_t w;
               w = wr_q.pop_front();
               check("wr_strobe", {31'd0, transmit_to_regfile}, 32'd1);
               check("wr_rd", {27'd0, regfile_pos_to_regfile}, {27'd0, w.rd});
               check("wr_data", data_to_regfile, w.data);
            end else begin
               check("wr_idle", {31'd0, transmit_to_regfile}, 32'd0);
            end
            if (pc_q.size() > 0) begin
               logic [31:0] tgt;
               tgt = pc_q.pop_front();
               check("pc_strobe", {31'd0, transmit_to_pc}, 32'd1);
               check("pc_target", pc_to_pc, tgt);
            end else begin
               check("pc_idle", {31'd0, transmit_to_pc}, 32'd0);
            end
         end
      end
   end

   // Stimulus: directed scenarios first, then a long randomized run.
   initial begin
      int acc0;
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 32'd0, 32'd0, 2'd0, 1'b0);
      // single ALU entry
      cyc(1'b0, 1'b1, 1'b1, 4'd3, 5'd5, 32'h1234, 32'd0, 2'b00, 1'b0);
      idle_cyc(1'b0);
      // three back-to-back entries, rd 0/7/9
      cyc(1'b0, 1'b1, 1'b1, 4'd4, 5'd0, 32'hA, 32'd0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 4'd5, 5'd7, 32'hB, 32'd0, 2'b10, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 4'd6, 5'd9, 32'hC, 32'd0, 2'b11, 1'b0);
      idle_cyc(1'b0);
      check("count_after_4", commit_count_out, 32'd4);
      // mispredicted jump with transmit held high afterwards
      cyc(1'b0, 1'b1, 1'b1, 4'd7, 5'd1, 32'h44, 32'h0000_1000, 2'b01, 1'b1);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b1, 1'b1, 4'd8, 5'd2, 32'h55, 32'h0, 2'b00, 1'b0);
      idle_cyc(1'b0);
      // correctly predicted jump
      cyc(1'b0, 1'b1, 1'b1, 4'd9, 5'd3, 32'h66, 32'h2000, 2'b01, 1'b0);
      // stall with valid entry, then release
      acc0 = n_acc;
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'b0, 1'b1, 4'd10, 5'd4, 32'h77, 32'h0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 4'd10, 5'd4, 32'h77, 32'h0, 2'b00, 1'b0);
      check("stall_accepts", n_acc - acc0, 32'd1);
      idle_cyc(1'b0);
      // reset in the first flush cycle
      cyc(1'b0, 1'b1, 1'b1, 4'd11, 5'd6, 32'h88, 32'h3000, 2'b01, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 4'd12, 5'd6, 32'h99, 32'h0, 2'b00, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 4'd13, 5'd8, 32'hAA, 32'h0, 2'b00, 1'b0);
      idle_cyc(1'b0);
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 3) != 0), 4'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
             $urandom, $urandom, 2'($urandom), ($urandom_range(0, 2) == 0));
      end
      idle_cyc(1'b0);
      idle_cyc(1'b0);
      repeat (2) @(negedge clk);
      check("wr_queue_drained", wr_q.size(), 32'd0);
      check("pc_queue_drained", pc_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
